square_wave_meter: RTL and testbench
====================================

Name: square_wave_meter

Overview:
- Sits directly downstream of hysteresis_comparator and consumes its square_wave output.
- Measures the square wave's period and high time in clk_100kHz cycles.
- Presents each period/high-time pair atomically with a one-cycle valid strobe.
- Flags loss of signal when no rising edge arrives within a timeout window.

Parameters:
- CNT_W, 16, width of the cycle counter and of the period/high_time outputs.
- TIMEOUT_CYC, 50000, cycles without a rising edge before no_signal is raised (0.5 s at 100 kHz); must be < 2^CNT_W.
- DEGLITCH_LEN, 3, consecutive equal samples required to accept a level change (used only with SQW_DEGLITCH_EN).

Ports:
- clk_100kHz  in  1  system clock, 100 kHz.
- rst  in  1  asynchronous, active-high reset.
- square_wave  in  1  comparator output; asynchronous to the meter and may glitch.
- clr  in  1  synchronous clear; forces the WAIT state.
- period  out  CNT_W  last measured period, in cycles.
- high_time  out  CNT_W  high time of that same period, in cycles.
- meas_valid  out  1  one-cycle strobe when period/high_time update.
- no_signal  out  1  level; 1 = no valid measurement currently held.
- level  out  1  synchronized (and filtered, if enabled) input level.

Behaviour:
- Reset values (rst=1, async): period=0, high_time=0, meas_valid=0, no_signal=1, level=0. Internal: sync flops=0, prev=0, cnt=0, hi_cap=0, state=WAIT.
- Input path:
  - 2-flop synchronizer feeds level.
  - rise = level & ~prev; fall = ~level & prev; prev is registered from level.
- FSM states: WAIT, MEASURE.
- WAIT:
  - cnt held at 0; falls ignored.
  - On rise: cnt<=1, go to MEASURE. No meas_valid on this first rise.
- MEASURE, cnt increments each cycle:
  - On fall: hi_cap<=cnt.
  - On rise:
    - period<=cnt, high_time<=hi_cap, meas_valid<=1 for one cycle, no_signal<=0.
    - cnt<=1; stay in MEASURE.
  - A periodic input with P cycles per period and H cycles high gives period=P, high_time=H.
  - Timeout: cnt==TIMEOUT_CYC with no rise that cycle:
    - period<=0, high_time<=0, no_signal<=1, cnt<=0, go to WAIT.
    - No meas_valid is issued.
  - Rise in the same cycle cnt==TIMEOUT_CYC: the rise wins and period=TIMEOUT_CYC.
  - Rise with no fall since the previous rise cannot occur (edges alternate). hi_cap still holds its prior value and is not checked.
- cnt never exceeds TIMEOUT_CYC, so there is no wrap-around.
- clr=1 (synchronous, highest priority below rst): same effect as timeout; rise/fall in that cycle are ignored.
- Latency: input rising edge to meas_valid is 3 cycles (2 sync + 1 output register) without the filter.
- period and high_time change only in the cycle meas_valid is high, or on timeout/clr/rst.
- Reset mid-measurement: all state is discarded immediately; the first rise after release restarts from WAIT.

Optional Feature:
- Macro: SQW_DEGLITCH_EN.
- Defined:
  - A filter between the synchronizer and level.
  - A counter tracks how long the synchronized input has differed from level. level toggles only after DEGLITCH_LEN consecutive differing samples; any agreeing sample resets the counter.
  - Pulses shorter than DEGLITCH_LEN cycles are invisible.
  - Latency grows by DEGLITCH_LEN cycles, applied equally to both edges, so period/high_time are unchanged.
- Undefined: level is taken directly from the synchronizer; no filter logic is generated.

Test Plan:
- Reset: assert rst mid-run -> period=0, high_time=0, meas_valid=0, no_signal=1 immediately; after release a 100/30 wave gives the first meas_valid only at the second rising edge.
- Steady wave, 100-cycle period with 30 cycles high -> period=100, high_time=30, meas_valid pulses every 100 cycles, no_signal=0 after the first strobe.
- Duty change from 30 high to 70 high (period 100) -> the next strobe after the change reports high_time=70, period=100; no intermediate mixed pair.
- Input held high for 50000+ cycles after a valid measurement -> at cnt==50000: no_signal=1, period=0, high_time=0, no meas_valid; resuming the 100/30 wave recovers after two rises.
- clr pulse during MEASURE -> outputs zeroed, no_signal=1, next valid measurement after two rises.
- With SQW_DEGLITCH_EN: 1- and 2-cycle low glitches inside the high phase of the 100/30 wave -> period=100, high_time=30, no extra strobes. Without the macro, the same stimulus produces a corrupted high_time.

Source files
------------

// File: rtl/square_wave_meter_if.sv
// square_wave_meter_if: square-wave input, clear and measurement outputs of the meter
interface square_wave_meter_if #(
    parameter int CNT_W = 16
);
    logic             square_wave;
    logic             clr;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             meas_valid;
    logic             no_signal;
    logic             level;

    modport master (
        output square_wave, clr,
        input  period, high_time, meas_valid, no_signal, level
    );

    modport slave (
        input  square_wave, clr,
        output period, high_time, meas_valid, no_signal, level
    );
endinterface

// File: rtl/square_wave_meter.sv
// square_wave_meter: measures period/high time of a square wave; SQW_DEGLITCH_EN adds an input filter
module square_wave_meter #(
    parameter int CNT_W        = 16,
    parameter int TIMEOUT_CYC  = 50000,
    parameter int DEGLITCH_LEN = 3
) (
    input  logic               clk_100kHz,
    input  logic               rst,
    square_wave_meter_if.slave bus
);
    typedef enum logic {WAIT, MEASURE} state_t;

    localparam logic [CNT_W-1:0] TO = CNT_W'(TIMEOUT_CYC);

    if (64'(TIMEOUT_CYC) >= (64'd1 << CNT_W) || DEGLITCH_LEN < 1) begin : g_bad_cfg
        $error("square_wave_meter: TIMEOUT_CYC must fit in CNT_W and DEGLITCH_LEN must be >= 1");
    end

    state_t           state, state_n;
    logic [1:0]       sync;
    logic             level, prev, rise, fall;
    logic [CNT_W-1:0] cnt, cnt_n, hi_cap, hi_cap_n;
    logic [CNT_W-1:0] period, period_n, high_time, high_time_n;
    logic             meas_valid, meas_valid_n, no_signal, no_signal_n;

    // two-flop synchronizer plus previous level for edge detection
    always_ff @(posedge clk_100kHz or posedge rst)
        if (rst) begin
            sync <= '0;
            prev <= 1'b0;
        end else begin
            sync <= {sync[0], bus.square_wave};
            prev <= level;
        end

`ifdef SQW_DEGLITCH_EN
    localparam int DG_W = $clog2(DEGLITCH_LEN + 1);
    logic [DG_W-1:0] dg_cnt;
    logic            level_q;

    // level flips only after DEGLITCH_LEN consecutive samples that disagree with it
    always_ff @(posedge clk_100kHz or posedge rst)
        if (rst) begin
            dg_cnt  <= '0;
            level_q <= 1'b0;
        end else if (sync[1] == level_q) begin
            dg_cnt <= '0;
        end else if (dg_cnt == DG_W'(DEGLITCH_LEN - 1)) begin
            dg_cnt  <= '0;
            level_q <= sync[1];
        end else begin
            dg_cnt <= dg_cnt + DG_W'(1);
        end

    assign level = level_q;
`else
    assign level = sync[1];
`endif

    assign rise = level & ~prev;
    assign fall = ~level & prev;

    // measurement FSM: clear/timeout abandon the measurement, rises close a period
    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        hi_cap_n     = hi_cap;
        period_n     = period;
        high_time_n  = high_time;
        meas_valid_n = 1'b0;
        no_signal_n  = no_signal;
        if (bus.clr || (state == MEASURE && !rise && cnt == TO)) begin
            state_n     = WAIT;
            cnt_n       = '0;
            period_n    = '0;
            high_time_n = '0;
            no_signal_n = 1'b1;
        end else if (state == WAIT) begin
            if (rise) begin
                cnt_n   = CNT_W'(1);
                state_n = MEASURE;
            end
        end else begin
            cnt_n = rise ? CNT_W'(1) : cnt + CNT_W'(1);
            if (fall)
                hi_cap_n = cnt;
            if (rise) begin
                period_n     = cnt;
                high_time_n  = hi_cap;
                meas_valid_n = 1'b1;
                no_signal_n  = 1'b0;
            end
        end
    end

    // state and measurement registers
    always_ff @(posedge clk_100kHz or posedge rst)
        if (rst) begin
            state      <= WAIT;
            cnt        <= '0;
            hi_cap     <= '0;
            period     <= '0;
            high_time  <= '0;
            meas_valid <= 1'b0;
            no_signal  <= 1'b1;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            hi_cap     <= hi_cap_n;
            period     <= period_n;
            high_time  <= high_time_n;
            meas_valid <= meas_valid_n;
            no_signal  <= no_signal_n;
        end

    assign bus.period     = period;
    assign bus.high_time  = high_time;
    assign bus.meas_valid = meas_valid;
    assign bus.no_signal  = no_signal;
    assign bus.level      = level;
endmodule

// File: tb/tb_square_wave_meter.sv
// tb_square_wave_meter: random and directed square waves checked against an edge-timestamp reference model
module tb_square_wave_meter;
    localparam int CNT_W = 16;
    localparam int TO    = 50000;
    localparam int DL    = 3;
    localparam int N     = 80000;
`ifdef SQW_DEGLITCH_EN
    localparam int D = 3;
`else
    localparam int D = 2;
`endif

    logic clk_100kHz = 1'b0;
    logic rst        = 1'b0;

    square_wave_meter_if #(.CNT_W(CNT_W)) bus ();

    square_wave_meter #(
        .CNT_W(CNT_W), .TIMEOUT_CYC(TO), .DEGLITCH_LEN(DL)
    ) dut (
        .clk_100kHz(clk_100kHz),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk_100kHz = ~clk_100kHz;

    int checks = 0;
    int errors = 0;

    bit x[N];
    bit z[N];
    int s = 8;
    bit armed = 1'b0;
    bit m_nosig = 1'b1;
    int m_period = 0, m_high = 0, last_rise = 0, last_fall = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at step %0d: got %0d expected %0d", tag, s, got, exp);
        end
    endtask

    task automatic step(input bit v, input bit c);
        int e;
        bit r, f, mv;
        if (s >= N) begin
            $display("FAIL step_budget: got %0d expected below %0d", s, N);
            $fatal(1);
        end
        bus.square_wave = v;
        bus.clr = c;
        x[s] = v;
`ifdef SQW_DEGLITCH_EN
        begin
            bit all_diff;
            all_diff = 1'b1;
            for (int k = 0; k < DL; k++)
                if (x[s-k] == z[s-1]) all_diff = 1'b0;
            z[s] = all_diff ? ~z[s-1] : z[s-1];
        end
`else
        z[s] = v;
`endif
        @(posedge clk_100kHz);
        #1;
        e  = s - D;
        r  = z[e] & ~z[e-1];
        f  = ~z[e] & z[e-1];
        mv = 1'b0;
        if (c) begin
            armed = 0; m_period = 0; m_high = 0; m_nosig = 1;
        end else if (armed) begin
            if (r) begin
                m_period = e - last_rise;
                m_high   = last_fall - last_rise;
                mv = 1; m_nosig = 0; last_rise = e;
            end else if (e - last_rise == TO) begin
                armed = 0; m_period = 0; m_high = 0; m_nosig = 1;
            end
            if (f) last_fall = e;
        end else if (r) begin
            armed = 1; last_rise = e;
        end
        check("level", bus.level, z[s-D+1]);
        check("meas_valid", bus.meas_valid, mv);
        check("period", bus.period, m_period);
        check("high_time", bus.high_time, m_high);
        check("no_signal", bus.no_signal, m_nosig);
        s++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.square_wave = 1'b0;
        bus.clr = 1'b0;
        #1;
        check("rst_period", bus.period, 0);
        check("rst_high_time", bus.high_time, 0);
        check("rst_meas_valid", bus.meas_valid, 0);
        check("rst_no_signal", bus.no_signal, 1);
        check("rst_level", bus.level, 0);
        for (int k = 0; k < 5; k++) begin
            x[s] = 0;
            z[s] = 0;
            @(posedge clk_100kHz);
            #1;
            s++;
        end
        rst = 1'b0;
        armed = 0; m_nosig = 1; m_period = 0; m_high = 0;
    endtask

    task automatic wave(input int p, input int h, input int n, input int clr_odds);
        for (int i = 0; i < n; i++)
            for (int j = 0; j < p; j++)
                step(j < h, clr_odds != 0 && $urandom_range(clr_odds - 1, 0) == 0);
    endtask

    task automatic glitch_wave(input int n);
        for (int i = 0; i < n; i++)
            for (int j = 0; j < 100; j++)
                step(j < 30 && j != 10 && j != 20 && j != 21, 1'b0);
    endtask

    initial begin
        int p, h;
        bus.square_wave = 1'b0;
        bus.clr = 1'b0;
        #2;
        do_reset();
        repeat (10) step(0, 0);
        wave(100, 30, 5, 0);
        wave(100, 70, 3, 0);
        wave(100, 30, 1, 0);
        repeat (40) step(1, 0);
        do_reset();
        wave(100, 30, 3, 0);
        repeat (10) step(1, 0);
        step(1, 1);
        repeat (20) step(1, 0);
        wave(100, 30, 3, 0);
        glitch_wave(4);
        wave(100, 30, 2, 0);
        repeat (20) begin
            p = $urandom_range(300, 4);
            h = $urandom_range(p - 1, 1);
            wave(p, h, $urandom_range(4, 2), 200);
        end
        wave(100, 30, 3, 0);
        repeat (TO + 10) step(1, 0);
        wave(100, 30, 3, 0);
        repeat (10) step(0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
